sad_prefix_accumulator: RTL and testbench

Parametrised successor to the team's 8-bit registered Sklansky adder. Each accepted sample pair (a, b) passes through a WIDTH-bit Sklansky prefix adder, configured as a sum or an absolute difference. The per-sample terms are accumulated over a block of BLOCK_LEN samples, and the block result is delivered on a valid/ready output port. The block sits between the pixel/sample input pins and the downstream SAD comparator/readout logic.

---
 rtl/sad_prefix_accumulator.sv | 197 +++++++++++++++++++
 tb/tb_sad_prefix_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sad_prefix_accumulator.sv
// rtl/sad_prefix_accumulator.sv - Sklansky sum/abs-diff per-sample term accumulated over blocks, valid/ready result port
module sad_prefix_accumulator #(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 16,
  parameter int ACC_W     = 13
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         mode,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             result,
  output logic [$clog2(BLOCK_LEN):0]   count,
  output logic                         sat
);

  localparam int CNT_W  = $clog2(BLOCK_LEN) + 1;
  localparam int LEVELS = $clog2(WIDTH + 1);

  // Position 0 of the prefix tree carries cin as a generate, so the tree spans WIDTH+1 positions.
  function automatic logic [WIDTH:0] sklansky_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             cin);
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    logic [WIDTH:0] g_n;
    logic [WIDTH:0] p_n;
    logic [WIDTH:0] s;
    int             j;
    g[0] = cin;
    p[0] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      g[k+1] = x[k] & y[k];
      p[k+1] = x[k] ^ y[k];
    end
    for (int l = 0; l < LEVELS; l++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i <= WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          j      = ((i >> l) << l) - 1;
          g_n[i] = g[i] | (p[i] & g[j]);
          p_n[i] = p[i] & p[j];
        end
      end
      g = g_n;
      p = p_n;
    end
    for (int k = 0; k < WIDTH; k++) begin
      s[k] = x[k] ^ y[k] ^ g[k];
    end
    s[WIDTH] = g[WIDTH];
    return s;
  endfunction

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             mode_q, mode_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_term_q, s1_term_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_first_q, s1_first_d;
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_int_q, sat_int_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  logic             advance;
  logic             take;
  logic             first_in;
  logic             last_in;
  logic             eff_mode;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   diff_ba;
  logic [WIDTH:0]   term;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;
  logic             sat_next;

  always_comb begin
    advance  = !out_valid_q | out_ready;
    in_ready = advance & reset_n;
    take     = in_valid & in_ready;
    first_in = (in_cnt_q == '0);
    last_in  = (in_cnt_q == CNT_W'(BLOCK_LEN - 1)) | flush;
    eff_mode = first_in ? mode : mode_q;

    sum_ab  = sklansky_add(a, b, 1'b0);
    diff_ab = sklansky_add(a, ~b, 1'b1);
    diff_ba = sklansky_add(b, ~a, 1'b1);
    // A clear carry out of a-b means a<b, so the magnitude comes from the b-a pass.
    if (!eff_mode) begin
      term = sum_ab;
    end else if (diff_ab[WIDTH]) begin
      term = {1'b0, diff_ab[WIDTH-1:0]};
    end else begin
      term = {1'b0, diff_ba[WIDTH-1:0]};
    end

    acc_sum  = {{(ACC_W - WIDTH){1'b0}}, s1_term_q} + (s1_first_q ? '0 : {1'b0, acc_q});
    acc_sat  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    sat_next = (!s1_first_q & sat_int_q) | acc_sum[ACC_W];

    in_cnt_d    = in_cnt_q;
    mode_d      = mode_q;
    s1_valid_d  = s1_valid_q;
    s1_term_d   = s1_term_q;
    s1_last_d   = s1_last_q;
    s1_first_d  = s1_first_q;
    s1_cnt_d    = s1_cnt_q;
    acc_d       = acc_q;
    sat_int_d   = sat_int_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    count_d     = count_q;
    sat_d       = sat_q;

    if (take) begin
      in_cnt_d = last_in ? '0 : in_cnt_q + CNT_W'(1);
      if (first_in) begin
        mode_d = mode;
      end
    end

    if (advance) begin
      s1_valid_d = take;
      if (take) begin
        s1_term_d  = term;
        s1_last_d  = last_in;
        s1_first_d = first_in;
        s1_cnt_d   = in_cnt_q + CNT_W'(1);
      end
    end

    if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end

    // A block completing in the handshake cycle overrides the clear above.
    if (advance & s1_valid_q) begin
      acc_d     = acc_sat;
      sat_int_d = sat_next;
      if (s1_last_q) begin
        result_d    = acc_sat;
        count_d     = s1_cnt_q;
        sat_d       = sat_next;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_cnt_q    <= '0;
      mode_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_term_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_cnt_q    <= '0;
      acc_q       <= '0;
      sat_int_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_term_q   <= s1_term_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      s1_cnt_q    <= s1_cnt_d;
      acc_q       <= acc_d;
      sat_int_q   <= sat_int_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign count     = count_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_sad_prefix_accumulator.sv
// tb/tb_sad_prefix_accumulator.sv - randomized and directed bench with a block-level reference model
module tb_sad_prefix_accumulator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        mode;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, sat_a;
  logic [12:0] result_a;
  logic [4:0]  count_a;
  logic        in_ready_b, out_valid_b, sat_b;
  logic [9:0]  result_b;
  logic [4:0]  count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rand_or = 1'b0;
  int bp_wait;

  typedef struct {
    int total;
    int n;
    int due;
  } blk_t;

  blk_t exp_q[$];
  int   m_total = 0;
  int   m_n     = 0;
  logic m_mode  = 1'b0;
  logic prev_ov = 1'b0;

  sad_prefix_accumulator u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .a(a), .b(b), .mode(mode), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .result(result_a), .count(count_a), .sat(sat_a)
  );

  sad_prefix_accumulator #(.ACC_W(10)) u_dut_sat (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .a(a), .b(b), .mode(mode), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .result(result_b), .count(count_b), .sat(sat_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int t, input int w);
    return (t >= (1 << w)) ? (1 << w) - 1 : t;
  endfunction

  // Reference model: whole-block arithmetic on the accepted samples.
  always @(negedge clock) begin
    blk_t e;
    int   term;
    if (!reset_n) begin
      check("rst_in_ready", in_ready_a, 0);
      check("rst_in_ready_sat", in_ready_b, 0);
      m_n = 0;
      m_total = 0;
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid_a) begin
        check("out_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("result", result_a, clip(e.total, 13));
          check("count", count_a, e.n);
          check("sat", sat_a, e.total >= 8192);
          check("valid_sat_dut", out_valid_b, 1);
          check("result_sat_dut", result_b, clip(e.total, 10));
          check("count_sat_dut", count_b, e.n);
          check("sat_sat_dut", sat_b, e.total >= 1024);
          if (!prev_ov) check("latency", cyc, e.due);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) begin
          check("bp_in_ready", in_ready_a, 0);
          check("bp_in_ready_sat", in_ready_b, 0);
        end
      end
      prev_ov = out_valid_a;
      if (in_valid && in_ready_a) begin
        if (m_n == 0) m_mode = mode;
        term = m_mode ? ((a >= b) ? int'(a) - int'(b) : int'(b) - int'(a)) : int'(a) + int'(b);
        m_total += term;
        m_n++;
        if (m_n == 16 || flush) begin
          e.total = m_total;
          e.n = m_n;
          e.due = cyc + 2;
          exp_q.push_back(e);
          m_n = 0;
          m_total = 0;
        end
      end
    end
  end

  task automatic send(input int av, input int bv, input logic md, input logic fl);
    int waited = 0;
    in_valid = 1'b1;
    a = av[7:0];
    b = bv[7:0];
    mode = md;
    flush = fl;
    @(negedge clock);
    while (!in_ready_a && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("send_timeout", waited < 200, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clock);
      w++;
    end
    #1;
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    mode = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_result", result_a, 0);
    check("rst_count", count_a, 0);
    check("rst_sat", sat_a, 0);
    check("rst_ready_now", in_ready_a, 0);
    reset_n = 1'b1;
    in_valid = 1'b0;

    for (int i = 0; i < 16; i++) send(255, 255, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) send(i[0] ? 250 : 10, i[0] ? 10 : 250, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) send(i[0] ? 250 : 10, i[0] ? 10 : 250, (i == 0) ? 1'b1 : i[1], 1'b0);
    drain();

    for (int i = 0; i < 5; i++) send(3, 1, 1'b1, i == 4);
    for (int i = 0; i < 3; i++) send(7, 2, 1'b0, i == 2);
    send(100, 50, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send(i * 7, 255 - i, 1'b1, i == 15);
    drain();

    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(200, 100, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(20, 30, 1'b0, 1'b0);
      end
      begin
        bp_wait = 0;
        while (!out_valid_a && bp_wait < 300) begin
          @(posedge clock);
          bp_wait++;
        end
        check("bp_wait_timeout", bp_wait < 300, 1);
        repeat (4) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 5; i++) send(9, 9, 1'b0, 1'b0);
    reset_n = 1'b0;
    idle(2);
    check("midrst_out_valid", out_valid_a, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) send(1, 2, 1'b1, 1'b0);
    drain();

    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0);
    end
    send(0, 0, 1'b0, 1'b1);
    rand_or = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
